sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 32 +++
 rtl/sync_fifo_param_if.sv | 44 ++++
 rtl/sync_fifo_ram.sv | 30 +++
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO:
// default sizes, the pointer-width helper, and the count-to-flag compare.
package sync_fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   // Status flags, all derived from a single occupancy value.
   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // Pointer and count width: index bits plus one wrap bit.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Map an occupancy onto the four status flags.
   function automatic fifo_flags_t calc_flags(input int cnt, input int depth,
                                              input int af_th, input int ae_th);
      fifo_flags_t f;
      f.full         = (cnt == depth);
      f.empty        = (cnt == 0);
      f.almost_full  = (cnt >= af_th);
      f.almost_empty = (cnt <= ae_th);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO.
// With SYNC_FIFO_ERR_STICKY_EN defined it also carries overflow/underflow.
interface sync_fifo_param_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);
   localparam int CNT_W = ptr_w(DEPTH);

   logic              wr;
   logic [DATA_W-1:0] data_in;
   logic              rd;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
`ifdef SYNC_FIFO_ERR_STICKY_EN
   logic              overflow;
   logic              underflow;
`endif

   // Side that pushes and pops words.
   modport master (
      output wr, data_in, rd,
      input  data_out, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_STICKY_EN
      , input overflow, underflow
`endif
   );

   // The FIFO itself.
   modport slave (
      input  wr, data_in, rd,
      output data_out, rd_valid, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_ERR_STICKY_EN
      , output overflow, underflow
`endif
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port and one registered
// read port, no reset, so a vendor RAM macro can replace it directly.
module sync_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];

   // Write port.
   // NOTE: the array has no reset on purpose; resetting it would prevent RAM
   // inference and the FIFO never reads a location it has not written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port; output holds when no read is issued.
   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and registered read data + valid.
// Optional macro SYNC_FIFO_ERR_STICKY_EN adds sticky overflow/underflow.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AF_TH  = DEPTH - 2,
   parameter int AE_TH  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   sync_fifo_param_if.slave bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int PTR_W  = ptr_w(DEPTH);

   // Reject configurations the pointer arithmetic and flags cannot support.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 2");
   end
   if (AF_TH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_TH must not exceed DEPTH");
   end
   if (AE_TH >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_param: AE_TH must be below DEPTH");
   end

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W-1:0]  count_q, count_nxt;
   fifo_flags_t       flags_q, flags_nxt;
   logic              wr_acc, rd_acc;
   logic              rd_valid_q;
   logic [DATA_W-1:0] ram_q, hold_q;

   // Accesses are qualified by the registered flags only.
   assign wr_acc = bus.wr & ~flags_q.full;
   assign rd_acc = bus.rd & ~flags_q.empty;

   // Next occupancy and the flags it implies.
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      count_nxt = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count_q + PTR_W'(1);
         2'b01:   count_nxt = count_q - PTR_W'(1);
         default: ;
      endcase
      flags_nxt = calc_flags(int'(count_nxt), DEPTH, AF_TH, AE_TH);
   end

   // Pointers, count, flags and read-valid strobe.
   // NOTE: state registers use non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         flags_q    <= calc_flags(0, DEPTH, AF_TH, AE_TH);
         rd_valid_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
         count_q    <= count_nxt;
         flags_q    <= flags_nxt;
         rd_valid_q <= rd_acc;
      end
   end

   // Resettable copy of the last word read, shown whenever rd_valid is low,
   // so data_out is 0 after reset even though the RAM register is not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          hold_q <= '0;
      else if (rd_valid_q) hold_q <= ram_q;
   end

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (bus.data_in),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (ram_q)
   );

   assign bus.data_out     = rd_valid_q ? ram_q : hold_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.count        = count_q;
   assign bus.full         = flags_q.full;
   assign bus.empty        = flags_q.empty;
   assign bus.almost_full  = flags_q.almost_full;
   assign bus.almost_empty = flags_q.almost_empty;

`ifdef SYNC_FIFO_ERR_STICKY_EN
   logic overflow_q, underflow_q;

   // Sticky error capture; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr && flags_q.full)  overflow_q  <= 1'b1;
         if (bus.rd && flags_q.empty) underflow_q <= 1'b1;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

   // Occupancy must always equal the pointer distance including wrap bits.
   a_count_ptr : assert property (@(posedge clk) disable iff (!rst_n)
                                  count_q == PTR_W'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF_TH=14,
// AE_TH=2) against a queue-based reference model.
module tb_sync_fifo_param;

   logic clk;
   logic rst_n;

   sync_fifo_param_if #(.DATA_W(8), .DEPTH(16)) bus ();

   sync_fifo_param #(
      .DATA_W (8),
      .DEPTH  (16),
      .AF_TH  (14),
      .AE_TH  (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [7:0] q [$];
   logic [7:0] exp_do;
   logic       exp_v;
   logic       exp_ovf;
   logic       exp_unf;
   int         peak;

   int n_cmp;
   int n_err;

   // Expected {count, full, empty, af, ae, rd_valid, overflow, underflow}.
   function automatic logic [11:0] exp_status();
      int n;
      n = q.size();
      return {5'(n), n == 16, n == 0, n >= 14, n <= 2, exp_v, exp_ovf, exp_unf};
   endfunction

   function automatic logic [11:0] obs_status();
      logic ovf, unf;
`ifdef SYNC_FIFO_ERR_STICKY_EN
      ovf = bus.overflow;
      unf = bus.underflow;
`else
      ovf = 1'b0;
      unf = 1'b0;
`endif
      return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
              bus.rd_valid, ovf, unf};
   endfunction

   function automatic void model_reset();
      q.delete();
      exp_do  = 8'h00;
      exp_v   = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
   endfunction

   // Drive one cycle of stimulus and advance the model; returns at edge+1.
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      logic was_full, was_empty;
      bus.wr = w;
      bus.data_in = d;
      bus.rd = r;
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      @(posedge clk);
      #1;
`ifdef SYNC_FIFO_ERR_STICKY_EN
      if (w && was_full)  exp_ovf = 1'b1;
      if (r && was_empty) exp_unf = 1'b1;
`endif
      exp_v = r && !was_empty;
      if (exp_v) exp_do = q.pop_front();
      if (w && !was_full) q.push_back(d);
      if (q.size() > peak) peak = q.size();
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      bus.data_in = 8'h00;
      model_reset();
      #12;
      if (obs_status() !== exp_status()) begin
         n_err++;
         $display("FAIL reset_status got=%h want=%h", obs_status(), exp_status());
      end
      n_cmp++;
      if (bus.data_out !== 8'h00) begin
         n_err++;
         $display("FAIL reset_data got=%h want=00", bus.data_out);
      end
      n_cmp++;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 33; i++) begin
         if (i < 16)       step(1'b1, 8'(i), 1'b0);
         else if (i == 16) step(1'b1, 8'hAA, 1'b0);
         else              step(1'b0, 8'h00, 1'b1);
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL fill_drain_status i=%0d got=%h want=%h", i, obs_status(), exp_status());
         end
         n_cmp++;
         if (bus.data_out !== exp_do) begin
            n_err++;
            $display("FAIL fill_drain_data i=%0d got=%h want=%h", i, bus.data_out, exp_do);
         end
         n_cmp++;
      end
      step(1'b0, 8'h00, 1'b0);
      if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_out !== 8'h0F) begin
         n_err++;
         $display("FAIL fill_drain_end got empty=%b v=%b d=%h want empty=1 v=0 d=0f",
                  bus.empty, bus.rd_valid, bus.data_out);
      end
      n_cmp++;
   endtask

   task automatic test_wrap();
      int plan [4] = '{10, 10, 12, 12};
      peak = 0;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < plan[p]; i++) begin
            if (p % 2 == 0) step(1'b1, 8'($urandom), 1'b0);
            else            step(1'b0, 8'h00, 1'b1);
            if (obs_status() !== exp_status()) begin
               n_err++;
               $display("FAIL wrap_status p=%0d i=%0d got=%h want=%h", p, i, obs_status(), exp_status());
            end
            n_cmp++;
            if (bus.data_out !== exp_do) begin
               n_err++;
               $display("FAIL wrap_data p=%0d i=%0d got=%h want=%h", p, i, bus.data_out, exp_do);
            end
            n_cmp++;
         end
      end
      if (peak != 12 || bus.count !== 5'd0) begin
         n_err++;
         $display("FAIL wrap_peak got peak=%0d count=%0d want peak=12 count=0", peak, bus.count);
      end
      n_cmp++;
   endtask

   task automatic test_simultaneous();
      // Seven writes, 20 paired cycles, drain 7, paired at empty,
      // fill to full, paired at full, drain the remaining 15.
      for (int i = 0; i < 7 + 20 + 7 + 1 + 15 + 1 + 15; i++) begin
         if (i < 7)       step(1'b1, 8'($urandom), 1'b0);
         else if (i < 27) step(1'b1, 8'($urandom), 1'b1);
         else if (i < 34) step(1'b0, 8'h00, 1'b1);
         else if (i < 35) step(1'b1, 8'h5C, 1'b1);
         else if (i < 50) step(1'b1, 8'($urandom), 1'b0);
         else if (i < 51) step(1'b1, 8'hEE, 1'b1);
         else             step(1'b0, 8'h00, 1'b1);
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL simult_status i=%0d got=%h want=%h", i, obs_status(), exp_status());
         end
         n_cmp++;
         if (bus.data_out !== exp_do) begin
            n_err++;
            $display("FAIL simult_data i=%0d got=%h want=%h", i, bus.data_out, exp_do);
         end
         n_cmp++;
         if (i == 34 && (bus.count !== 5'd1 || bus.rd_valid !== 1'b0)) begin
            n_err++;
            $display("FAIL simult_empty got count=%0d v=%b want count=1 v=0", bus.count, bus.rd_valid);
         end
         if (i == 34) n_cmp++;
         if (i == 50 && (bus.count !== 5'd15 || bus.full !== 1'b0)) begin
            n_err++;
            $display("FAIL simult_full got count=%0d full=%b want count=15 full=0", bus.count, bus.full);
         end
         if (i == 50) n_cmp++;
      end
   endtask

   task automatic test_random();
      logic w, r;
      for (int i = 0; i < 400; i++) begin
         // Alternate write-heavy and read-heavy phases to visit both ends.
         if ((i / 50) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         step(w, 8'($urandom), r);
         if (obs_status() !== exp_status()) begin
            n_err++;
            $display("FAIL random_status i=%0d got=%h want=%h", i, obs_status(), exp_status());
         end
         n_cmp++;
         if (bus.data_out !== exp_do) begin
            n_err++;
            $display("FAIL random_data i=%0d got=%h want=%h", i, bus.data_out, exp_do);
         end
         n_cmp++;
      end
   endtask

   task automatic test_reset_mid_burst();
      while (q.size() > 0) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h11 * 8'(i + 1), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      if (bus.rd_valid !== 1'b1 || bus.data_out !== 8'h11) begin
         n_err++;
         $display("FAIL midrst_pre got v=%b d=%h want v=1 d=11", bus.rd_valid, bus.data_out);
      end
      n_cmp++;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      if (obs_status() !== exp_status()) begin
         n_err++;
         $display("FAIL midrst_status got=%h want=%h", obs_status(), exp_status());
      end
      n_cmp++;
      if (bus.data_out !== 8'h00) begin
         n_err++;
         $display("FAIL midrst_data got=%h want=00", bus.data_out);
      end
      n_cmp++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      if (obs_status() !== exp_status()) begin
         n_err++;
         $display("FAIL midrst_post got=%h want=%h", obs_status(), exp_status());
      end
      n_cmp++;
   endtask

`ifdef SYNC_FIFO_ERR_STICKY_EN
   task automatic test_sticky();
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      if (bus.underflow !== 1'b1 || bus.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL sticky_set got ovf=%b unf=%b want 1 1", bus.overflow, bus.underflow);
      end
      n_cmp++;
      if (obs_status() !== exp_status()) begin
         n_err++;
         $display("FAIL sticky_status got=%h want=%h", obs_status(), exp_status());
      end
      n_cmp++;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL sticky_clear got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow);
      end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      peak  = 0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_random();
      test_reset_mid_burst();
`ifdef SYNC_FIFO_ERR_STICKY_EN
      test_sticky();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
